display_mux_7seg: RTL and testbench
===================================

Name: display_mux_7seg

Overview:
- Parametrised successor to the single-digit 4-bit-to-7-segment decoder: drives N multiplexed 7-segment digits from one shared segment bus, scanning digits time-sliced by a prescaled counter.
- Adds value capture, decimal/hex mode, an error glyph for invalid decimal codes, leading-zero suppression and per-digit decimal point.
- Sits between the datapath (BCD/hex result registers) and the board's display pins.

Parameters:
- N_DIGITS, 4, number of digits scanned (2..8).
- SCAN_DIV, 50000, clock cycles per digit slot (>=2).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous reset, active-low, sampled on rising clk edge.
- data_in  input  4*N_DIGITS  digit codes; digit 0 = bits[3:0] (least significant).
- dp_in  input  N_DIGITS  decimal-point request per digit.
- load  input  1  capture data_in/dp_in into the shadow registers.
- hex_mode  input  1  1 = codes 0..F shown as hex; 0 = decimal, codes A..F shown as error glyph.
- lz_en  input  1  1 = leading-zero suppression on.
- en  input  1  display enable (0 = all dark, scanning continues).
- seg  output  7  segments, active-high, bit0=a … bit6=g.
- dp  output  1  decimal-point segment, active-high.
- dig_sel  output  N_DIGITS  one-hot digit enable, active-high.

Behaviour:
- Reset (rst_n=0 at a clk edge): shadow data=0, shadow dp=0, prescaler=0, digit index=0, seg=0, dp=0, dig_sel=0. Reset has priority over load and over any scan in progress; it takes effect at the next edge.
- Capture: a load=1 at an edge copies data_in/dp_in into the shadow registers. With load=0, shadow registers hold their value. Outputs are driven only from the shadow registers, never directly from data_in.
- Prescaler counts 0..SCAN_DIV-1 and wraps to 0. The scan tick is asserted when prescaler==SCAN_DIV-1.
- Digit index advances on each tick: 0→1→…→N_DIGITS-1→0. Each digit is lit for exactly SCAN_DIV cycles.
- Outputs are registered, with 1-cycle latency from index or shadow change to seg/dp/dig_sel.
- A load in the same cycle as a tick is legal: index advances and new data is shown one cycle later.
- Digit select: when en=1, dig_sel = one-hot(index); when en=0, dig_sel=0, seg=0, dp=0.
- Segment encoding (hex, seg[6:0]):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- Decimal mode (hex_mode=0): codes 0..9 use the table above; codes A..F display 40 (dash, g only).
- Leading-zero suppression (lz_en=1): digit k is blanked (seg=0) when digit k and every higher digit hold code 0. Digit 0 is never blanked. dp is not affected by blanking.
- dp output = shadow dp bit of the current index (gated by en).
- hex_mode and lz_en are combinational selects on the shadow data; a change appears on the outputs 1 cycle later.
- Synthesisable. No latches. No multi-driven nets. Scanning never stalls.

Test Plan:
- Reset and scan order (N_DIGITS=4, SCAN_DIV=4): hold rst_n=0 for 3 cycles, then release with en=1 → seg=0 and dig_sel=0 while in reset; afterwards dig_sel steps 0001→0010→0100→1000→0001, each value held 4 cycles.
- Hex capture: load data_in=16'h1A3F, dp_in=4'b0100, hex_mode=1, lz_en=0 → digits 0..3 show seg 71, 4F, 77, 06; dp=1 only when dig_sel=0100.
- Decimal error glyph: data_in=16'h9B20, hex_mode=0 → seg 3F, 5B, 40, 6F for digits 0..3.
- Leading-zero suppression: data_in=16'h0005, lz_en=1 → digits 3,2,1 give seg=00 and digit 0 gives 6D. data_in=16'h0000 → only digit 0 lit, showing 3F. Repeat with lz_en=0 → digits 3..1 show 3F.
- Enable gating and load/tick collision: en=0 for 10 cycles → seg/dp/dig_sel all 0 while the index keeps advancing; load on a tick edge → new value visible exactly 1 cycle later.
- Mid-scan reset: assert rst_n=0 while dig_sel=0100 with shadow=16'h1234 → next edge gives all outputs 0; after release, digit 0 shows 3F (shadow cleared).

Source files
------------

// File: rtl/display_mux_7seg.sv
// display_mux_7seg
//   Drives N_DIGITS multiplexed 7-segment digits from one shared segment bus.
//   Digit codes are captured into shadow registers on load. Each digit slot
//   lasts SCAN_DIV clock cycles. Supports hex/decimal display (invalid decimal
//   codes show a dash), leading-zero suppression and a per-digit decimal point.
//   All outputs are registered, one cycle behind the scan index / shadow data.
//
// Ports
//   clk      in   system clock, rising edge
//   rst_n    in   synchronous active-low reset
//   data_in  in   4*N_DIGITS digit codes, digit 0 in bits [3:0]
//   dp_in    in   N_DIGITS decimal-point requests
//   load     in   capture data_in/dp_in into the shadow registers
//   hex_mode in   1 = hex glyphs, 0 = decimal (A..F shown as dash)
//   lz_en    in   leading-zero suppression enable
//   en       in   display enable (0 = dark, scanning continues)
//   seg      out  segments a..g on bits 0..6, active-high
//   dp       out  decimal-point segment, active-high
//   dig_sel  out  one-hot digit enable, active-high
module display_mux_7seg #(
  parameter int N_DIGITS = 4,
  parameter int SCAN_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*N_DIGITS-1:0] data_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic                  load,
  input  logic                  hex_mode,
  input  logic                  lz_en,
  input  logic                  en,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [N_DIGITS-1:0]   dig_sel
);

  localparam int PRE_W = $clog2(SCAN_DIV);
  localparam int IDX_W = $clog2(N_DIGITS);

  logic [4*N_DIGITS-1:0] data_q, data_d;
  logic [N_DIGITS-1:0]   dps_q, dps_d;
  logic [PRE_W-1:0]      pre_q, pre_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dpo_q, dpo_d;
  logic [N_DIGITS-1:0]   sel_q, sel_d;

  logic       tick;
  logic [3:0] code;
  logic       dp_cur;
  logic       higher_nz;
  logic       blank;

  // Hex glyph table; in decimal mode codes above 9 become a dash (g only).
  function automatic logic [6:0] seg7(input logic [3:0] c, input logic hex);
    logic [6:0] s;
    case (c)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    if (!hex && (c > 4'd9)) s = 7'h40;
    return s;
  endfunction

  always_comb begin
    tick   = (pre_q == PRE_W'(SCAN_DIV - 1));
    pre_d  = tick ? '0 : pre_q + 1'b1;
    idx_d  = idx_q;
    if (tick) idx_d = (idx_q == IDX_W'(N_DIGITS - 1)) ? '0 : idx_q + 1'b1;

    data_d = load ? data_in : data_q;
    dps_d  = load ? dp_in : dps_q;

    // Select the current digit and check whether it and all digits above it
    // are zero, which is the leading-zero blanking condition.
    code      = 4'h0;
    dp_cur    = 1'b0;
    higher_nz = 1'b0;
    sel_d     = '0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (IDX_W'(k) == idx_q) begin
        code   = data_q[4*k +: 4];
        dp_cur = dps_q[k];
      end
      if ((IDX_W'(k) >= idx_q) && (data_q[4*k +: 4] != 4'h0)) higher_nz = 1'b1;
      sel_d[k] = en && (IDX_W'(k) == idx_q);
    end
    blank = lz_en && (idx_q != '0) && !higher_nz;

    seg_d = (en && !blank) ? seg7(code, hex_mode) : 7'h00;
    dpo_d = en && dp_cur;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q <= '0;
      dps_q  <= '0;
      pre_q  <= '0;
      idx_q  <= '0;
      seg_q  <= '0;
      dpo_q  <= 1'b0;
      sel_q  <= '0;
    end else begin
      data_q <= data_d;
      dps_q  <= dps_d;
      pre_q  <= pre_d;
      idx_q  <= idx_d;
      seg_q  <= seg_d;
      dpo_q  <= dpo_d;
      sel_q  <= sel_d;
    end
  end

  assign seg     = seg_q;
  assign dp      = dpo_q;
  assign dig_sel = sel_q;

endmodule

// File: tb/tb_display_mux_7seg.sv
// Testbench for display_mux_7seg (N_DIGITS=4, SCAN_DIV=4).
// Stimulus pushes per-cycle expected outputs into a queue; a negedge monitor
// pops and compares them against the DUT outputs.
module tb_display_mux_7seg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] data_in;
  logic [3:0]  dp_in;
  logic        load, hex_mode, lz_en, en;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  dig_sel;

  display_mux_7seg #(.N_DIGITS(4), .SCAN_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .dp_in(dp_in), .load(load),
    .hex_mode(hex_mode), .lz_en(lz_en), .en(en),
    .seg(seg), .dp(dp), .dig_sel(dig_sel)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] sel;
    string      name;
  } item_t;

  item_t q[$];
  int cyc = 0;
  int p0 = 0;
  int checks = 0;
  int errors = 0;

  logic [6:0] exp_seg [4];
  logic       exp_dp  [4];
  bit         exp_dark;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation due in this cycle.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      item_t it;
      it = q.pop_front();
      checks++;
      if (seg !== it.seg || dp !== it.dp || dig_sel !== it.sel || it.cyc != cyc) begin
        errors++;
        $display("FAIL %s cyc=%0d got seg=%h dp=%b sel=%b, expected seg=%h dp=%b sel=%b (due cyc %0d)",
                 it.name, cyc, seg, dp, dig_sel, it.seg, it.dp, it.sel, it.cyc);
      end
    end
  end

  // Digit on the outputs after edge c: each slot is 4 cycles, the first
  // edge after reset release shows digit 0.
  function automatic int dig(input int c);
    return ((c - p0 - 1) / 4) % 4;
  endfunction

  task automatic check_cycles(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      item_t it;
      int d;
      @(posedge clk);
      #1;
      it.cyc  = cyc;
      it.name = name;
      if (exp_dark) begin
        it.seg = 7'h00; it.dp = 1'b0; it.sel = 4'b0000;
      end else begin
        d = dig(cyc);
        it.seg = exp_seg[d]; it.dp = exp_dp[d]; it.sel = 4'b0001 << d;
      end
      q.push_back(it);
    end
  endtask

  task automatic set_tbl(input logic [6:0] s0, s1, s2, s3, input logic [3:0] dpv);
    exp_seg[0] = s0; exp_seg[1] = s1; exp_seg[2] = s2; exp_seg[3] = s3;
    for (int k = 0; k < 4; k++) exp_dp[k] = dpv[k];
  endtask

  // Load edge is checked against the old table; mode changes land with load=0.
  task automatic do_load(input logic [15:0] d, input logic [3:0] dpv,
                         input logic hx, input logic lz, input string name);
    data_in = d; dp_in = dpv; load = 1'b1;
    check_cycles(1, name);
    load = 1'b0; hex_mode = hx; lz_en = lz;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; data_in = 16'h0; dp_in = 4'h0; load = 1'b0;
    hex_mode = 1'b1; lz_en = 1'b0; en = 1'b1;
    set_tbl(7'h3F, 7'h3F, 7'h3F, 7'h3F, 4'b0000);

    exp_dark = 1'b1;
    check_cycles(3, "reset");
    p0 = cyc; rst_n = 1'b1; exp_dark = 1'b0;
    check_cycles(20, "scan_order");

    do_load(16'h1A3F, 4'b0100, 1'b1, 1'b0, "hex_load_edge");
    set_tbl(7'h71, 7'h4F, 7'h77, 7'h06, 4'b0100);
    check_cycles(16, "hex_capture");

    do_load(16'h9B20, 4'b0000, 1'b0, 1'b0, "dec_load_edge");
    set_tbl(7'h3F, 7'h5B, 7'h40, 7'h6F, 4'b0000);
    check_cycles(16, "dec_error_glyph");

    do_load(16'h0005, 4'b1000, 1'b1, 1'b1, "lz_load_edge");
    set_tbl(7'h6D, 7'h00, 7'h00, 7'h00, 4'b1000);
    check_cycles(16, "lz_0005");

    do_load(16'h0000, 4'b0000, 1'b1, 1'b1, "lz0_load_edge");
    set_tbl(7'h3F, 7'h00, 7'h00, 7'h00, 4'b0000);
    check_cycles(16, "lz_0000");

    lz_en = 1'b0;
    set_tbl(7'h3F, 7'h3F, 7'h3F, 7'h3F, 4'b0000);
    check_cycles(16, "lz_off");

    en = 1'b0; exp_dark = 1'b1;
    check_cycles(10, "en_off");
    en = 1'b1; exp_dark = 1'b0;
    check_cycles(8, "en_back");

    // Align so the load edge is also a scan tick.
    while (((cyc + 1 - p0) % 4) != 0) check_cycles(1, "pre_tick");
    do_load(16'h4567, 4'b0001, 1'b1, 1'b0, "tick_load_edge");
    set_tbl(7'h07, 7'h7D, 7'h6D, 7'h66, 4'b0001);
    check_cycles(1, "tick_load_next");
    check_cycles(8, "tick_load_after");

    do_load(16'h1234, 4'b0000, 1'b1, 1'b0, "mid_load_edge");
    set_tbl(7'h66, 7'h4F, 7'h5B, 7'h06, 4'b0000);
    check_cycles(1, "mid_pre");
    while (dig(cyc) != 2) check_cycles(1, "mid_pre");
    rst_n = 1'b0; exp_dark = 1'b1;
    check_cycles(1, "mid_reset");
    p0 = cyc; rst_n = 1'b1; exp_dark = 1'b0;
    set_tbl(7'h3F, 7'h3F, 7'h3F, 7'h3F, 4'b0000);
    check_cycles(8, "post_reset");

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
